// File: rtl/rf_pkg.sv
// Shared types for the register-file write scheduler.
// Optional write-to-read forwarding is enabled by defining RF_WRITE_BYPASS_EN.
package rf_pkg;

    localparam int RF_DEPTH  = 64;
    localparam int RF_ADDR_W = 6;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_e;

    function automatic req_e req_other(input req_e r);
        return (r == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/rf_bank.sv
// Register-file storage: one 64x1 distributed dual-port RAM slice per data bit.
// One synchronous write port, one asynchronous read port, no reset.
module rf_bank
    import rf_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 we,
    input  logic [RF_ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]     wd,
    input  logic [RF_ADDR_W-1:0] ra,
    output logic [WIDTH-1:0]     rd
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic mem_q [RF_DEPTH];

        always_ff @(posedge CLK) begin
            if (we) begin
                mem_q[wa] <= wd[i];
            end
        end

        assign rd[i] = mem_q[ra];
    end

endmodule

// File: rtl/rf_write_sched.sv
// Write-port scheduler: post-reset clear sweep, then round-robin A/B arbitration.
// Define RF_WRITE_BYPASS_EN to forward a granted write to a matching read.
module rf_write_sched
    import rf_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                 CLK,
    input  logic                 Reset_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [RF_ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]     a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [RF_ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]     b_data,
    input  logic [RF_ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 init_done
);

    state_e               state_q, state_d;
    logic [RF_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    req_e                 rr_ptr_q, rr_ptr_d;
    logic                 init_done_q, init_done_d;

    logic                 run;
    logic                 ram_we;
    logic [RF_ADDR_W-1:0] ram_wa;
    logic [WIDTH-1:0]     ram_wd;
    logic [WIDTH-1:0]     bank_rd;
    logic [WIDTH-1:0]     rd_mux;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            rr_ptr_q    <= REQ_A;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == RF_ADDR_W'(RF_DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Pointer moves only when both sides compete.
                if (a_valid && b_valid) begin
                    rr_ptr_d = req_other(rr_ptr_q);
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        init_done_d = (state_d == ST_RUN);
    end

    always_comb begin
        run     = (state_q == ST_RUN);
        a_ready = run && a_valid
                  && (!b_valid || rr_ptr_q == REQ_A);
        b_ready = run && b_valid
                  && (!a_valid || rr_ptr_q == REQ_B);
        ram_we  = 1'b0;
        ram_wa  = clr_cnt_q;
        ram_wd  = INIT_VAL;
        unique case (1'b1)
            !run: begin
                ram_we = 1'b1;
            end
            a_ready: begin
                ram_we = 1'b1;
                ram_wa = a_addr;
                ram_wd = a_data;
            end
            b_ready: begin
                ram_we = 1'b1;
                ram_wa = b_addr;
                ram_wd = b_data;
            end
            default: ;
        endcase
    end

    rf_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .CLK (CLK),
        .we  (ram_we),
        .wa  (ram_wa),
        .wd  (ram_wd),
        .ra  (rd_addr),
        .rd  (bank_rd)
    );

`ifdef RF_WRITE_BYPASS_EN
    always_comb begin
        rd_mux = bank_rd;
        if (run && ram_we && ram_wa == rd_addr) begin
            rd_mux = ram_wd;
        end
    end
`else
    assign rd_mux = bank_rd;
`endif

    assign rd_data   = init_done_q ? rd_mux : '0;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_write_sched.sv
// Scoreboard bench for rf_write_sched: random and directed writes
// against a queue/array reference model.
module tb_rf_write_sched;

    localparam int          W  = 32;
    localparam logic [31:0] IV = 32'h0BAD_F00D;

    logic          clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic          a_ready, b_ready;
    logic [5:0]    a_addr = '0, b_addr = '0, rd_addr = '0;
    logic [W-1:0]  a_data = '0, b_data = '0;
    logic [W-1:0]  rd_data;
    logic          init_done;

    rf_write_sched #(
        .WIDTH    (W),
        .INIT_VAL (IV)
    ) dut (
        .CLK       (clk),
        .Reset_n   (Reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ar;
        logic        br;
        logic [31:0] rd;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] mem [64];
    int          clr_left = 0;
    bit          turn_b = 1'b0;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     n, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("a_ready", 32'(a_ready), 32'(e.ar));
            chk("b_ready", 32'(b_ready), 32'(e.br));
            chk("init_done", 32'(init_done), 32'(e.done));
            chk("rd_data", rd_data, e.rd);
        end
    end

    task automatic rst();
        a_valid = 0;
        b_valid = 0;
        Reset_n = 0;
        @(posedge clk);
        #1;
        Reset_n  = 1;
        clr_left = 64;
        turn_b   = 1'b0;
    endtask

    task automatic step(input bit av, input logic [5:0] aa,
                        input logic [31:0] ad, input bit bv,
                        input logic [5:0] ba, input logic [31:0] bd,
                        input logic [5:0] ra,
                        output bit ga, output bit gb);
        exp_t e;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        rd_addr = ra;
        ga = 0;
        gb = 0;
        e  = '0;
        if (clr_left == 0) begin
            if (av && bv) begin
                if (turn_b) gb = 1; else ga = 1;
                turn_b = !turn_b;
            end else begin
                ga = av;
                gb = bv;
            end
            e.ar   = ga;
            e.br   = gb;
            e.done = 1'b1;
            e.rd   = mem[ra];
`ifdef RF_WRITE_BYPASS_EN
            if (ga && aa == ra) e.rd = ad;
            if (gb && ba == ra) e.rd = bd;
`endif
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0)
                for (int i = 0; i < 64; i++) mem[i] = IV;
        end else begin
            if (ga) mem[aa] = ad;
            if (gb) mem[ba] = bd;
        end
    endtask

    task automatic idle(input logic [5:0] ra);
        bit ga, gb;
        step(0, '0, '0, 0, '0, '0, ra, ga, gb);
    endtask

    initial begin
        bit         ga, gb;
        bit         ap, bp;
        logic [5:0] pa, pb;
        logic [31:0] da, db;

        rst();
        repeat (64) idle(6'($urandom_range(0, 63)));
        for (int i = 0; i < 64; i++) idle(6'(i));

        step(1, 6'd5, 32'hDEADBEEF, 0, '0, '0, 6'd5, ga, gb);
        idle(6'd5);

        repeat (4) step(1, 6'd1, 32'hA1, 1, 6'd2, 32'hB2, 6'd1, ga, gb);
        idle(6'd1);
        idle(6'd2);

        step(1, 6'd7, 32'h11, 1, 6'd7, 32'h22, 6'd7, ga, gb);
        step(0, 6'd7, 32'h11, 1, 6'd7, 32'h22, 6'd7, ga, gb);
        idle(6'd7);

        step(1, 6'd9, 32'h55, 0, '0, '0, 6'd9, ga, gb);
        idle(6'd9);

        ap = 0; bp = 0;
        pa = '0; pb = '0; da = '0; db = '0;
        repeat (400) begin
            if (!ap && $urandom_range(0, 2) != 0) begin
                ap = 1; pa = 6'($urandom_range(0, 63)); da = $urandom;
            end else if (ap && $urandom_range(0, 9) == 0) begin
                ap = 0;
            end
            if (!bp && $urandom_range(0, 2) != 0) begin
                bp = 1; pb = 6'($urandom_range(0, 63)); db = $urandom;
            end else if (bp && $urandom_range(0, 9) == 0) begin
                bp = 0;
            end
            step(ap, pa, da, bp, pb, db,
                 6'($urandom_range(0, 63)), ga, gb);
            if (ga) ap = 0;
            if (gb) bp = 0;
        end

        for (int i = 0; i < 64; i++)
            step(1, 6'(i), $urandom, 0, '0, '0, 6'(i), ga, gb);
        rst();
        repeat (30) idle(6'($urandom_range(0, 63)));
        rst();
        repeat (64) idle(6'($urandom_range(0, 63)));
        for (int i = 0; i < 64; i++) idle(6'(63 - i));
        step(1, 6'd9, 32'h55, 0, '0, '0, 6'd9, ga, gb);
        idle(6'd9);

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0",
                     sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
